// File: rtl/csc_pkg.sv
// Shared constants for the colorspace converter and its 4:2:2 packer.
package csc_pkg;
  localparam int DW_DEF      = 12;
  localparam int CSC_LAT_DEF = 3;
  localparam logic [DW_DEF-1:0] C_BLANK = DW_DEF'(1) << (DW_DEF-1);

  localparam int IDX_Y  = 0;
  localparam int IDX_CB = 1;
  localparam int IDX_CR = 2;

  typedef enum logic {PH_EVEN = 1'b0, PH_ODD = 1'b1} phase_e;
endpackage

// File: rtl/csc_yuv422_packer_if.sv
// Pixel bus between the colorspace converter output and the 4:2:2 packer.
interface csc_yuv422_packer_if #(parameter int DW = 12);
  logic          vsync_i, hsync_i, de_i;
  logic [DW-1:0] din0, din1, din2;
  logic          vsync_o, hsync_o, de_o;
  logic [DW-1:0] y_o, c_o;
  logic          cb_flag_o;

  modport master (
    output vsync_i, hsync_i, de_i, din0, din1, din2,
    input  vsync_o, hsync_o, de_o, y_o, c_o, cb_flag_o
  );
  modport slave (
    input  vsync_i, hsync_i, de_i, din0, din1, din2,
    output vsync_o, hsync_o, de_o, y_o, c_o, cb_flag_o
  );
endinterface

// File: rtl/csc_sync_delay.sv
// N-stage delay line for the {vsync,hsync,de} timing triple.
module csc_sync_delay #(
  parameter int N = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [2:0] d,
  output logic [2:0] q
);
  logic [N-1:0][2:0] sr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < N; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[N-1];
endmodule

// File: rtl/csc_yuv422_packer.sv
// 4:4:4 -> 4:2:2 packer: pairs pixels, averages chroma with rounding, and
// realigns the raw timing signals with the converter output.
module csc_yuv422_packer
  import csc_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int CSC_LAT = CSC_LAT_DEF
) (
  input  logic clk,
  input  logic rstn,
  csc_yuv422_packer_if.slave bus
);
  localparam logic [DW-1:0] CBLK = {1'b1, {(DW-1){1'b0}}};

  logic [2:0]         tim_a, tim_o;   // {vsync, hsync, de}
  logic [2:0][DW-1:0] pix;
  logic               de_a, vs_a, vs_q, vs_rise, is_odd;
  phase_e             state;

  logic [DW-1:0] y_e, cb_e, cr_e, y_od, cr_avg;
  logic          even_pend, odd_pend;
  logic [DW:0]   cb_sum, cr_sum;

  logic [DW-1:0] y_r, c_r;
  logic          flag_r;

  csc_sync_delay #(.N(CSC_LAT)) u_dly_a (
    .clk (clk), .rstn (rstn),
    .d   ({bus.vsync_i, bus.hsync_i, bus.de_i}),
    .q   (tim_a)
  );

  // The data path adds two cycles (hold + output register) after alignment.
  csc_sync_delay #(.N(2)) u_dly_o (
    .clk (clk), .rstn (rstn),
    .d   (tim_a),
    .q   (tim_o)
  );

  assign pix     = {bus.din2, bus.din1, bus.din0};
  assign de_a    = tim_a[0];
  assign vs_a    = tim_a[2];
  assign vs_rise = vs_a & ~vs_q;
  assign is_odd  = de_a && (state == PH_ODD) && !vs_rise;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= PH_EVEN;
      vs_q  <= 1'b0;
    end else begin
      vs_q  <= vs_a;
      state <= (de_a && !is_odd) ? PH_ODD : PH_EVEN;
    end
  end

  assign cb_sum = {1'b0, cb_e} + {1'b0, pix[IDX_CB]} + {{DW{1'b0}}, 1'b1};
  assign cr_sum = {1'b0, cr_e} + {1'b0, pix[IDX_CR]} + {{DW{1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      y_e       <= '0;
      cb_e      <= '0;
      cr_e      <= '0;
      y_od      <= '0;
      cr_avg    <= '0;
      even_pend <= 1'b0;
      odd_pend  <= 1'b0;
    end else begin
      even_pend <= de_a && !is_odd;
      odd_pend  <= is_odd;
      if (de_a && !is_odd) begin
        y_e  <= pix[IDX_Y];
        cb_e <= pix[IDX_CB];
        cr_e <= pix[IDX_CR];
      end
      if (is_odd) begin
        y_od   <= pix[IDX_Y];
        cr_avg <= cr_sum[DW:1];
      end
    end
  end

  // An even pixel with no odd partner this cycle goes out with its own Cb.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      y_r    <= '0;
      c_r    <= '0;
      flag_r <= 1'b0;
    end else if (even_pend) begin
      y_r    <= y_e;
      c_r    <= is_odd ? cb_sum[DW:1] : cb_e;
      flag_r <= 1'b1;
    end else if (odd_pend) begin
      y_r    <= y_od;
      c_r    <= cr_avg;
      flag_r <= 1'b0;
    end else begin
      y_r    <= '0;
      c_r    <= CBLK;
      flag_r <= 1'b0;
    end
  end

  assign {bus.vsync_o, bus.hsync_o, bus.de_o} = tim_o;
  assign bus.y_o       = y_r;
  assign bus.c_o       = c_r;
  assign bus.cb_flag_o = flag_r;
endmodule
